// File: rtl/fantastic_ifft8_if.sv
// Bus bundle for fantastic_ifft8: a y-side spectrum frame in and an x-side sample frame out.
// The master modport drives spectra and observes samples; the IFFT core takes the slave modport.
interface fantastic_ifft8_if;
   logic              isValid;
   logic signed [7:-8] y0, y1, y2, y3, y4, y5, y6, y7;
   logic signed [7:-8] y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i;
   logic              x_valid;
   logic signed [7:-8] x0, x1, x2, x3, x4, x5, x6, x7;
   logic signed [7:-8] x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i;

   modport master (
      output isValid,
      output y0, y1, y2, y3, y4, y5, y6, y7,
      output y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i,
      input  x_valid,
      input  x0, x1, x2, x3, x4, x5, x6, x7,
      input  x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i
   );

   modport slave (
      input  isValid,
      input  y0, y1, y2, y3, y4, y5, y6, y7,
      input  y0_i, y1_i, y2_i, y3_i, y4_i, y5_i, y6_i, y7_i,
      output x_valid,
      output x0, x1, x2, x3, x4, x5, x6, x7,
      output x0_i, x1_i, x2_i, x3_i, x4_i, x5_i, x6_i, x7_i
   );
endinterface

// File: rtl/fantastic_ifft8.sv
// Four-rank pipelined 8-point radix-2 DIT inverse FFT on Q8.8 complex frames, one frame per cycle.
// Define FANTASTIC_IFFT8_SCALE_EN to halve every butterfly output (overall 1/8, a true inverse).
module fantastic_ifft8 (
   input  logic             clk,
   input  logic             rst_n,
   fantastic_ifft8_if.slave bus
);

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } cpx_t;

   localparam logic signed [15:0] C_Q = 16'sh00B5;

   function automatic logic signed [15:0] bf_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
`ifdef FANTASTIC_IFFT8_SCALE_EN
      // One guard bit keeps the sum exact before the halving shift.
      return 16'((17'(a) + 17'(b)) >>> 1);
`else
      return a + b;
`endif
   endfunction

   function automatic logic signed [15:0] bf_sub(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
`ifdef FANTASTIC_IFFT8_SCALE_EN
      return 16'((17'(a) - 17'(b)) >>> 1);
`else
      return a - b;
`endif
   endfunction

   function automatic cpx_t cadd(input cpx_t a, input cpx_t b);
      cpx_t r;
      r.re = bf_add(a.re, b.re);
      r.im = bf_add(a.im, b.im);
      return r;
   endfunction

   function automatic cpx_t csub(input cpx_t a, input cpx_t b);
      cpx_t r;
      r.re = bf_sub(a.re, b.re);
      r.im = bf_sub(a.im, b.im);
      return r;
   endfunction

   function automatic logic signed [15:0] mul_c(input logic signed [15:0] v);
      return 16'((32'(v) * 32'(C_Q)) >>> 8);
   endfunction

   // Multiplying by +j is a swap with negation, so it costs no multiplier.
   function automatic cpx_t mul_j(input cpx_t v);
      cpx_t r;
      r.re = -v.im;
      r.im = v.re;
      return r;
   endfunction

   function automatic cpx_t mul_w1(input cpx_t v);
      cpx_t r;
      logic signed [15:0] pr, pi;
      pr   = mul_c(v.re);
      pi   = mul_c(v.im);
      r.re = pr - pi;
      r.im = pr + pi;
      return r;
   endfunction

   function automatic cpx_t mul_w3(input cpx_t v);
      cpx_t r;
      logic signed [15:0] pr, pi;
      pr   = mul_c(v.re);
      pi   = mul_c(v.im);
      r.re = -pr - pi;
      r.im = pr - pi;
      return r;
   endfunction

   cpx_t [7:0] y_br, r0, s1, r1, b, tw, r2, xs, r3;
   logic [3:0] vld;

   // Bins enter rank 0 already in bit-reversed order 0,4,2,6,1,5,3,7.
   assign y_br[0] = '{re: bus.y0, im: bus.y0_i};
   assign y_br[1] = '{re: bus.y4, im: bus.y4_i};
   assign y_br[2] = '{re: bus.y2, im: bus.y2_i};
   assign y_br[3] = '{re: bus.y6, im: bus.y6_i};
   assign y_br[4] = '{re: bus.y1, im: bus.y1_i};
   assign y_br[5] = '{re: bus.y5, im: bus.y5_i};
   assign y_br[6] = '{re: bus.y3, im: bus.y3_i};
   assign y_br[7] = '{re: bus.y7, im: bus.y7_i};

   // NOTE: give every always_comb target a full default first so no path can infer a latch.
   always_comb begin
      s1 = '0;
      for (int m = 0; m < 8; m += 2) begin
         s1[m]   = cadd(r0[m], r0[m+1]);
         s1[m+1] = csub(r0[m], r0[m+1]);
      end
   end

   always_comb begin
      b  = '0;
      tw = '0;
      for (int g = 0; g < 8; g += 4) begin
         b[g]   = cadd(r1[g], r1[g+2]);
         b[g+2] = csub(r1[g], r1[g+2]);
         b[g+1] = cadd(r1[g+1], mul_j(r1[g+3]));
         b[g+3] = csub(r1[g+1], mul_j(r1[g+3]));
      end
      tw    = b;
      tw[5] = mul_w1(b[5]);
      tw[6] = mul_j(b[6]);
      tw[7] = mul_w3(b[7]);
   end

   always_comb begin
      xs = '0;
      for (int k = 0; k < 4; k++) begin
         xs[k]   = cadd(r2[k], r2[k+4]);
         xs[k+4] = csub(r2[k], r2[k+4]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every rank samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r0  <= '0;
         r1  <= '0;
         r2  <= '0;
         r3  <= '0;
         vld <= '0;
      end else begin
         r0  <= y_br;
         r1  <= s1;
         r2  <= tw;
         r3  <= xs;
         vld <= {vld[2:0], bus.isValid};
      end
   end

   assign bus.x_valid = vld[3];
   assign bus.x0   = r3[0].re;
   assign bus.x1   = r3[1].re;
   assign bus.x2   = r3[2].re;
   assign bus.x3   = r3[3].re;
   assign bus.x4   = r3[4].re;
   assign bus.x5   = r3[5].re;
   assign bus.x6   = r3[6].re;
   assign bus.x7   = r3[7].re;
   assign bus.x0_i = r3[0].im;
   assign bus.x1_i = r3[1].im;
   assign bus.x2_i = r3[2].im;
   assign bus.x3_i = r3[3].im;
   assign bus.x4_i = r3[4].im;
   assign bus.x5_i = r3[5].im;
   assign bus.x6_i = r3[6].im;
   assign bus.x7_i = r3[7].im;

endmodule

// File: tb/tb_fantastic_ifft8.sv
// Scoreboard bench for fantastic_ifft8: a direct-DFT reference predicts each frame, a monitor checks it.
// Build with or without FANTASTIC_IFFT8_SCALE_EN to match the RTL configuration.
module tb_fantastic_ifft8;

   typedef int  vec8_t  [8];
   typedef real rvec8_t [8];
   typedef struct {
      int  due;
      int  kind;
      int  tol;
      real er [8];
      real ei [8];
   } exp_t;

   localparam int K_RAND = 0, K_IMP = 1, K_DC = 2, K_OVF = 3, K_RT = 4;
`ifdef FANTASTIC_IFFT8_SCALE_EN
   localparam bit SCALED = 1'b1;
   localparam int RAND_LIM = 16383;
`else
   localparam bit SCALED = 1'b0;
   localparam int RAND_LIM = 1023;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];

   fantastic_ifft8_if bus ();

   fantastic_ifft8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string what, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", what, detail);
      end
   endtask

   function automatic string kname(input int k);
      case (k)
         K_IMP:   return "impulse";
         K_DC:    return "dc";
         K_OVF:   return "overflow";
         K_RT:    return "roundtrip";
         default: return "random";
      endcase
   endfunction

   // x[n] = s * sum_k Y[k] * W^(-nk), with the conjugate twiddles quantised to c = 181/256.
   function automatic void model(input vec8_t yr, input vec8_t yi,
                                 output rvec8_t er, output rvec8_t ei);
      real c, sr, si;
      real wr [8];
      real wi [8];
      c  = 181.0 / 256.0;
      wr = '{1.0, c, 0.0, -c, -1.0, -c, 0.0, c};
      wi = '{0.0, c, 1.0, c, 0.0, -c, -1.0, -c};
      for (int n = 0; n < 8; n++) begin
         sr = 0.0;
         si = 0.0;
         for (int k = 0; k < 8; k++) begin
            sr += yr[k] * wr[(n * k) % 8] - yi[k] * wi[(n * k) % 8];
            si += yr[k] * wi[(n * k) % 8] + yi[k] * wr[(n * k) % 8];
         end
         er[n] = SCALED ? sr / 8.0 : sr;
         ei[n] = SCALED ? si / 8.0 : si;
      end
   endfunction

   // Distance between a 16-bit result and the ideal value, modulo 2^16 wrap.
   function automatic real wrapdiff(input int act, input real want);
      real d;
      d = act - want;
      while (d >= 32768.0) d -= 65536.0;
      while (d < -32768.0) d += 65536.0;
      return d;
   endfunction

   task automatic drive(input vec8_t yr, input vec8_t yi, input bit v);
      bus.isValid = v;
      bus.y0 = 16'(yr[0]);  bus.y0_i = 16'(yi[0]);
      bus.y1 = 16'(yr[1]);  bus.y1_i = 16'(yi[1]);
      bus.y2 = 16'(yr[2]);  bus.y2_i = 16'(yi[2]);
      bus.y3 = 16'(yr[3]);  bus.y3_i = 16'(yi[3]);
      bus.y4 = 16'(yr[4]);  bus.y4_i = 16'(yi[4]);
      bus.y5 = 16'(yr[5]);  bus.y5_i = 16'(yi[5]);
      bus.y6 = 16'(yr[6]);  bus.y6_i = 16'(yi[6]);
      bus.y7 = 16'(yr[7]);  bus.y7_i = 16'(yi[7]);
   endtask

   task automatic sample(output vec8_t xr, output vec8_t xi);
      xr[0] = bus.x0;  xi[0] = bus.x0_i;
      xr[1] = bus.x1;  xi[1] = bus.x1_i;
      xr[2] = bus.x2;  xi[2] = bus.x2_i;
      xr[3] = bus.x3;  xi[3] = bus.x3_i;
      xr[4] = bus.x4;  xi[4] = bus.x4_i;
      xr[5] = bus.x5;  xi[5] = bus.x5_i;
      xr[6] = bus.x6;  xi[6] = bus.x6_i;
      xr[7] = bus.x7;  xi[7] = bus.x7_i;
   endtask

   task automatic rand_frame(output vec8_t yr, output vec8_t yi);
      for (int k = 0; k < 8; k++) begin
         yr[k] = int'($urandom_range(2 * RAND_LIM)) - RAND_LIM;
         yi[k] = int'($urandom_range(2 * RAND_LIM)) - RAND_LIM;
      end
   endtask

   // Presents one valid frame in the next cycle and queues its expected result 4 cycles later.
   task automatic send(input vec8_t yr, input vec8_t yi, input int kind, input int tol);
      exp_t   e;
      rvec8_t er, ei;
      @(posedge clk); #1;
      drive(yr, yi, 1'b1);
      model(yr, yi, er, ei);
      if (kind == K_RT) begin
         for (int n = 0; n < 8; n++) begin
            er[n] = 256.0 * (n + 1);
            ei[n] = 0.0;
         end
      end
      e.due  = cyc + 4;
      e.kind = kind;
      e.tol  = tol;
      e.er   = er;
      e.ei   = ei;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      vec8_t yr, yi;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rand_frame(yr, yi);
         drive(yr, yi, 1'b0);
      end
   endtask

   initial begin : monitor
      exp_t  e;
      vec8_t xr, xi;
      forever begin
         @(negedge clk);
         if (bus.x_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check(bus.x_valid === 1'b0, "spurious_valid",
                     $sformatf("x_valid=1 at cycle %0d, want 0 (no frame due)", cyc));
            end else begin
               e = sb.pop_front();
               check(cyc == e.due, $sformatf("%s latency", kname(e.kind)),
                     $sformatf("x_valid at cycle %0d, want cycle %0d", cyc, e.due));
               sample(xr, xi);
               for (int n = 0; n < 8; n++) begin
                  check((wrapdiff(xr[n], e.er[n]) <= e.tol) && (wrapdiff(xr[n], e.er[n]) >= -e.tol),
                        $sformatf("%s x%0d", kname(e.kind), n),
                        $sformatf("got %0d want %0.2f (tol %0d) cycle %0d", xr[n], e.er[n], e.tol, cyc));
                  check((wrapdiff(xi[n], e.ei[n]) <= e.tol) && (wrapdiff(xi[n], e.ei[n]) >= -e.tol),
                        $sformatf("%s x%0d_i", kname(e.kind), n),
                        $sformatf("got %0d want %0.2f (tol %0d) cycle %0d", xi[n], e.ei[n], e.tol, cyc));
               end
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check(bus.x_valid === 1'b1, $sformatf("%s missing_valid", kname(e.kind)),
                  $sformatf("x_valid=%b at cycle %0d, want 1 (due %0d)", bus.x_valid, cyc, e.due));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      vec8_t yr, yi, zr, zi, xr, xi;
      int    c0;

      zr = '{0, 0, 0, 0, 0, 0, 0, 0};
      zi = zr;
      drive(zr, zi, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sample(xr, xi);
      check(bus.x_valid === 1'b0, "reset x_valid", $sformatf("got %b want 0", bus.x_valid));
      for (int n = 0; n < 8; n++) begin
         check(xr[n] == 0, $sformatf("reset x%0d", n), $sformatf("got %0d want 0", xr[n]));
         check(xi[n] == 0, $sformatf("reset x%0d_i", n), $sformatf("got %0d want 0", xi[n]));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Impulse, then DC, each isolated.
      yr = '{2048, 0, 0, 0, 0, 0, 0, 0};
      send(yr, zi, K_IMP, 0);
      idle(6);
      yr = '{2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048};
      send(yr, zi, K_DC, 0);
      idle(6);

      // Back-to-back impulse, DC, impulse.
      yr = '{2048, 0, 0, 0, 0, 0, 0, 0};
      send(yr, zi, K_IMP, 0);
      yr = '{2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048};
      send(yr, zi, K_DC, 0);
      yr = '{2048, 0, 0, 0, 0, 0, 0, 0};
      send(yr, zi, K_IMP, 0);
      idle(6);

      // All bins at 127.0: wraps unscaled, exact when scaled.
      yr = '{32512, 32512, 32512, 32512, 32512, 32512, 32512, 32512};
      send(yr, zi, K_OVF, 0);
      idle(6);

`ifdef FANTASTIC_IFFT8_SCALE_EN
      // FFT8 spectrum of samples 1..8 must come back as n+1 within 0.05.
      yr = '{9216, -1024, -1024, -1024, -1024, -1024, -1024, -1024};
      yi = '{0, 2472, 1024, 424, 0, -424, -1024, -2472};
      send(yr, yi, K_RT, 12);
      idle(6);
`endif

      // Random frames with random gaps.
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(3) == 0) idle(int'($urandom_range(2)) + 1);
         rand_frame(yr, yi);
         send(yr, yi, K_RAND, 4);
      end
      idle(8);

      // Reset mid-flight: frame in c, reset in c+2, released in c+3.
      rand_frame(yr, yi);
      @(posedge clk); #1;
      c0 = cyc;
      drive(yr, yi, 1'b1);
      idle(1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(yr, yi, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(zr, zi, 1'b0);
      @(negedge clk);
      sample(xr, xi);
      check(cyc == c0 + 3 && bus.x_valid === 1'b0, "midreset x_valid c+3",
            $sformatf("got x_valid=%b at cycle %0d, want 0 at cycle %0d", bus.x_valid, cyc, c0 + 3));
      for (int n = 0; n < 8; n++) begin
         check(xr[n] == 0, $sformatf("midreset x%0d", n), $sformatf("got %0d want 0", xr[n]));
         check(xi[n] == 0, $sformatf("midreset x%0d_i", n), $sformatf("got %0d want 0", xi[n]));
      end
      for (int i = 4; i <= 6; i++) begin
         idle(1);
         @(negedge clk);
         check(bus.x_valid === 1'b0, $sformatf("midreset x_valid c+%0d", i),
               $sformatf("got %b want 0", bus.x_valid));
      end

      // The pipeline must run normally again after the reset.
      for (int i = 0; i < 8; i++) begin
         rand_frame(yr, yi);
         send(yr, yi, K_RAND, 4);
      end
      idle(1);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      check(sb.size() == 0, "drain", $sformatf("%0d frames still pending, want 0", sb.size()));
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
